// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: captures one 128-bit state, transforms COLS_PER_CYCLE columns per clock.
// Optional macro INV_MIX_EN adds the InvMixColumns datapath, selected by the decrypt bit captured with the state.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // For COLS_PER_CYCLE=4 the step truncates to 0, so the single group both starts and ends at column 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
            a0 ^ x1 ^ x2 ^ a2 ^ a3,
            a0 ^ a1 ^ x2 ^ x3 ^ a3,
            x0 ^ a0 ^ a1 ^ a2 ^ x3};
  endfunction

`ifdef INV_MIX_EN
  // Inverse coefficients built from the 2x/4x/8x multiples: 09=8+1, 0B=8+2+1, 0D=8+4+1, 0E=8+4+2.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  state_t      state_q, state_d;
  logic [1:0]  col_cnt_q, col_cnt_d;
  logic [31:0] src_col_q [4];
  logic [31:0] res_col_q [4];
  logic [31:0] res_col_d [4];
  logic        accept;
  logic        last_group;

  logic [2*COLS_PER_CYCLE-1:0]  grp_idx;
  logic [32*COLS_PER_CYCLE-1:0] grp_out;

  assign accept     = in_valid && in_ready;
  assign last_group = (col_cnt_q == LAST_COL);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_group) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      CALC: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef INV_MIX_EN
  logic dec_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q <= 1'b0;
    end else if (accept) begin
      dec_q <= decrypt;
    end
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  // Input capture register; contents are don't-care until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        src_col_q[k] <= in_data[127-32*k -: 32];
      end
    end
  end

  // One transform lane per column handled in a cycle.
  generate
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
      logic [1:0]  col_idx;
      logic [31:0] fwd_col;
      assign col_idx = col_cnt_q + 2'(gi);
      assign fwd_col = mix_fwd(src_col_q[col_idx]);
      assign grp_idx[2*gi +: 2] = col_idx;
`ifdef INV_MIX_EN
      assign grp_out[32*gi +: 32] = dec_q ? mix_inv(src_col_q[col_idx]) : fwd_col;
`else
      assign grp_out[32*gi +: 32] = fwd_col;
`endif
    end
  endgenerate

  always_comb begin
    col_cnt_d = col_cnt_q;
    if (accept) begin
      col_cnt_d = '0;
    end else if (state_q == CALC) begin
      col_cnt_d = col_cnt_q + COL_STEP;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      res_col_d[k] = res_col_q[k];
    end
    if (state_q == CALC) begin
      for (int l = 0; l < COLS_PER_CYCLE; l++) begin
        res_col_d[grp_idx[2*l +: 2]] = grp_out[32*l +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      for (int k = 0; k < 4; k++) begin
        res_col_q[k] <= '0;
      end
    end else begin
      col_cnt_q <= col_cnt_d;
      for (int k = 0; k < 4; k++) begin
        res_col_q[k] <= res_col_d[k];
      end
    end
  end

  assign out_data = {res_col_q[0], res_col_q[1], res_col_q[2], res_col_q[3]};

  // A stalled result must not move until the downstream stage takes it.
  a_hold_output: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  a_ready_busy_excl: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready != busy);

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: vector table plus scoreboard, with latency, reset,
// backpressure, back-to-back spacing and decrypt sequences.
module tb_mix_columns_iter;

  localparam int CPC = 1;
  localparam int LAT = 4 / CPC;
`ifdef INV_MIX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COLS_IN  = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
  localparam logic [127:0] COLS_OUT = 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         decrypt = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .decrypt   (decrypt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    logic [127:0] data;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] exp;
    int           tag;
  } sb_t;

  vec_t         tbl [7];
  sb_t          sb_q [$];
  int           acc_cyc_q [$];
  int           cyc = 0;
  int           n_pass = 0;
  int           n_total = 0;
  logic [127:0] exp_cur = '0;
  int           tag_cur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference: out[r] = XOR_k coef[(k-r) mod 4] * a[k], per column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [127:0] r = '0;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) a[rr] = s[127-32*c-8*rr -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o = o ^ gmul(a[k], coef[(k - rr + 4) % 4]);
        r[127-32*c-8*rr -: 8] = o;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s: got no event, required event within bound", name);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %h, required no output", out_data);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        $display("output tag=%0d data=%h cyc=%0d", e.tag, out_data, cyc);
        check($sformatf("out_data_tag%0d", e.tag), out_data, e.exp);
      end
    end
    if (rst_n && in_valid && in_ready) begin
      sb_t e;
      e.exp = exp_cur;
      e.tag = tag_cur;
      sb_q.push_back(e);
      acc_cyc_q.push_back(cyc);
      $display("accept tag=%0d data=%h dec=%0b cyc=%0d", tag_cur, in_data, decrypt, cyc);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [127:0] d, input logic dec, input logic [127:0] exp, input int tag);
    int waited = 0;
    in_data  = d;
    decrypt  = dec;
    exp_cur  = exp;
    tag_cur  = tag;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        note_fail("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    decrypt  = ~dec;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        note_fail("drain_timeout");
        sb_q.delete();
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] bp_data;
    logic [127:0] bp_exp;
    logic [127:0] inv_exp;
    int           n;

    tbl[0] = '{FIPS_IN, 1'b0, FIPS_OUT};
    tbl[1] = '{COLS_IN, 1'b0, COLS_OUT};
    tbl[2] = '{128'h0, 1'b0, 128'h0};
    for (int i = 3; i < 7; i++) begin
      tbl[i].data = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].dec  = (i % 2) == 0;
      tbl[i].exp  = ref_mix(tbl[i].data, tbl[i].dec && INV_EN);
    end

    // Power-up reset
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_data", out_data, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 round 1 with latency check
    send(FIPS_IN, 1'b0, FIPS_OUT, 0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("latency_early", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    check("latency_on_time", 128'(out_valid), 128'd1);
    wait_drain();

    // Reset for two edges in the middle of a block
    send(tbl[3].data, tbl[3].dec, tbl[3].exp, 1);
    @(posedge clk);
    #1;
    check("midcalc_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_out_valid", 128'(out_valid), 128'd0);
    check("midreset_out_data", out_data, 128'd0);
    check("midreset_in_ready", 128'(in_ready), 128'd1);
    sb_q.delete();
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("after_reset_no_output", 128'(out_valid), 128'd0);

    // Vector table applied back-to-back with in_valid held high
    acc_cyc_q.delete();
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].data, tbl[i].dec, tbl[i].exp, 10 + i);
    end
    wait_drain();
    check("b2b_accept_count", 128'(acc_cyc_q.size()), 128'd7);
    for (int i = 1; i < acc_cyc_q.size(); i++) begin
      check($sformatf("b2b_spacing_%0d", i), 128'(acc_cyc_q[i] - acc_cyc_q[i-1]), 128'(LAT + 2));
    end

    // Backpressure: hold the result for 10 cycles while in_valid pulses
    bp_data = {$urandom, $urandom, $urandom, $urandom};
    bp_exp  = ref_mix(bp_data, 1'b0);
    out_ready = 1'b0;
    send(bp_data, 1'b0, bp_exp, 30);
    n = 0;
    while (!out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        note_fail("bp_out_valid_timeout");
        break;
      end
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      in_data  = ~bp_data;
      @(posedge clk);
      #1;
      check($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'd1);
      check($sformatf("bp_out_data_%0d", i), out_data, bp_exp);
      check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_extra_output", 128'(out_valid), 128'd0);

    // Inverse request; forward result when the inverse datapath is absent
    inv_exp = INV_EN ? FIPS_IN : ref_mix(FIPS_OUT, 1'b0);
    send(FIPS_OUT, 1'b1, inv_exp, 40);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
